// File: rtl/ls299.sv
`timescale 1ns/1ps
// ls299: 8-bit universal shift/storage register with 3-state parallel port (74LS299 behaviour).
// Define LS299_TIMING_EN to model propagation delays; the default build is zero-delay.
module ls299 #(
   parameter int TPD_CLK_Q = 22,
   parameter int TPD_CLR_Q = 26,
   parameter int TPD_OE    = 18
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       S0,
   input  logic       S1,
   input  logic       G1_n,
   input  logic       G2_n,
   input  logic       SR,
   input  logic       SL,
   inout  wire  [7:0] IO,
   output logic       QA_s,
   output logic       QH_s
);

   logic [7:0] r_q;
   logic [7:0] w_qNext;
   logic       w_oe;

   // Negative delays are meaningless and indicate a mis-configured instance.
   if (TPD_CLK_Q < 0 || TPD_CLR_Q < 0 || TPD_OE < 0) begin : g_badDelay
      $error("ls299: propagation delays must be non-negative");
   end

   // Undefined select bits load all-X so an unconfigured board state is visible.
   always_comb begin
      w_qNext = r_q;
      case ({S1, S0})
         2'b00:   w_qNext = r_q;
         2'b01:   w_qNext = {r_q[6:0], SR};
         2'b10:   w_qNext = {SL, r_q[7:1]};
         2'b11:   w_qNext = IO;
         default: w_qNext = 'x;
      endcase
   end

   // Load mode always releases the bus so the capture sees external data only.
   assign w_oe = !G1_n && !G2_n && !(S1 && S0);

`ifdef LS299_TIMING_EN
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_q <= #TPD_CLR_Q 8'h00;
      end else begin
         r_q <= #TPD_CLK_Q w_qNext;
      end
   end

   assign #TPD_OE IO = w_oe ? r_q : 8'bzzzz_zzzz;
`else
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_q <= 8'h00;
      end else begin
         r_q <= w_qNext;
      end
   end

   assign IO = w_oe ? r_q : 8'bzzzz_zzzz;
`endif

   assign QA_s = r_q[0];
   assign QH_s = r_q[7];

endmodule

// File: tb/tb_ls299.sv
`timescale 1ns/1ps
// tb_ls299: randomized scoreboard bench for the ls299 shift/storage register.
// Expected values come from a byte-arithmetic reference model of the register.
module tb_ls299;

`ifdef LS299_TIMING_EN
   localparam int HALF   = 60;
   localparam int SETTLE = 45;
`else
   localparam int HALF   = 10;
   localparam int SETTLE = 1;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       s0 = 1'b0;
   logic       s1 = 1'b0;
   logic       g1n = 1'b1;
   logic       g2n = 1'b1;
   logic       sr = 1'b0;
   logic       sl = 1'b0;
   logic       tbDrive = 1'b0;
   logic [7:0] tbData = 8'h00;
   wire  [7:0] io;
   logic       qaS;
   logic       qhS;

   assign io = tbDrive ? tbData : 8'bzzzz_zzzz;

   ls299 dut (
      .CLK (clk),
      .CLR (clr),
      .S0  (s0),
      .S1  (s1),
      .G1_n(g1n),
      .G2_n(g2n),
      .SR  (sr),
      .SL  (sl),
      .IO  (io),
      .QA_s(qaS),
      .QH_s(qhS)
   );

   always #HALF clk = ~clk;

   // kind 0: bus shows the register, kind 1: serial ends, kind 2: bus released
   typedef struct {
      int         kind;
      logic [7:0] exp;
      string      name;
   } expItem_t;

   expItem_t   sbQueue[$];
   event       obsEv;
   int         checkCount = 0;
   int         passCount = 0;
   logic [7:0] modelQ = 8'h00;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req,
                              input bit wantEqual);
      checkCount++;
      if (wantEqual ? (act === req) : (act !== req)) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, required %s%h", name, act, wantEqual ? "" : "anything but ", req);
      end
   endtask

   // Reference behaviour expressed as arithmetic on the byte value.
   function automatic logic [7:0] refNext(input logic [1:0] mode, input logic [7:0] q,
                                          input logic srIn, input logic slIn, input logic [7:0] bus);
      int v;
      v = int'(q);
      case (mode)
         2'd1:    v = (v * 2 + int'(srIn)) % 256;
         2'd2:    v = v / 2 + 128 * int'(slIn);
         2'd3:    v = int'(bus);
         default: v = int'(q);
      endcase
      return v[7:0];
   endfunction

   task automatic push(input int kind, input logic [7:0] exp, input string name);
      expItem_t it;
      it.kind = kind;
      it.exp  = exp;
      it.name = name;
      sbQueue.push_back(it);
   endtask

   // Monitor: drains every pending expectation once the outputs have settled.
   initial begin
      expItem_t it;
      forever begin
         @(obsEv);
         #SETTLE;
         while (sbQueue.size() > 0) begin
            it = sbQueue.pop_front();
            case (it.kind)
               0:       checkOutput(it.name, io, it.exp, 1'b1);
               1:       checkOutput(it.name, {6'b0, qhS, qaS}, {6'b0, it.exp[7], it.exp[0]}, 1'b1);
               default: checkOutput(it.name, io, it.exp, 1'b0);
            endcase
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] mode, input logic srIn, input logic slIn,
                                input logic [7:0] bus, input string name);
      @(negedge clk);
      {s1, s0} = mode;
      sr       = srIn;
      sl       = slIn;
      g1n      = 1'b1;
      g2n      = 1'b1;
      tbDrive  = (mode == 2'b11);
      tbData   = bus;
      @(posedge clk);
      if (clr) modelQ = 8'h00;
      else     modelQ = refNext(mode, modelQ, srIn, slIn, bus);
      push(1, modelQ, name);
      ->obsEv;
   endtask

   // Briefly enables the bus between edges so the whole register can be read.
   task automatic observe(input logic [1:0] mode, input string name);
      @(negedge clk);
      {s1, s0} = mode;
      g1n      = 1'b0;
      g2n      = 1'b0;
      tbDrive  = 1'b0;
      #1;
      push(0, modelQ, name);
      push(1, modelQ, {name, "_ser"});
      ->obsEv;
      #(SETTLE + 3);
      g1n      = 1'b1;
      g2n      = 1'b1;
      {s1, s0} = 2'b00;
   endtask

   task automatic checkReleased(input logic g1, input logic g2, input logic [1:0] mode,
                                input string name);
      @(negedge clk);
      {s1, s0} = mode;
      g1n      = g1;
      g2n      = g2;
      tbDrive  = 1'b0;
      #1;
      push(2, modelQ, name);
      push(1, modelQ, {name, "_ser"});
      ->obsEv;
      #(SETTLE + 3);
      g1n      = 1'b1;
      g2n      = 1'b1;
      {s1, s0} = 2'b00;
   endtask

   task automatic pulseClear(input string name);
      @(negedge clk);
      {s1, s0} = 2'b00;
      tbDrive  = 1'b0;
      clr      = 1'b1;
      #2;
      clr      = 1'b0;
      modelQ   = 8'h00;
      g1n      = 1'b0;
      g2n      = 1'b0;
      #1;
      push(0, modelQ, name);
      push(1, modelQ, {name, "_ser"});
      ->obsEv;
      #(SETTLE + 3);
      g1n      = 1'b1;
      g2n      = 1'b1;
   endtask

   initial begin
      logic [1:0] m;
      int         pick;

      #1;
      clr = 1'b1;
      #1;
      push(1, 8'h00, "reset_serial");
      ->obsEv;

      // Clear held across a load edge with A5 on the bus
      applyStimulus(2'b11, 1'b0, 1'b0, 8'hA5, "clr_over_load");
      observe(2'b00, "clr_hold_q");
      clr = 1'b0;
      applyStimulus(2'b11, 1'b0, 1'b0, 8'hA5, "load_a5");
      observe(2'b00, "q_a5");

      applyStimulus(2'b11, 1'b0, 1'b0, 8'h81, "load_81");
      for (int i = 0; i < 8; i++) applyStimulus(2'b01, 1'b1, 1'b0, 8'h00, $sformatf("shr_%0d", i));
      observe(2'b00, "shr_final");

      applyStimulus(2'b11, 1'b0, 1'b0, 8'h3C, "load_3c");
      for (int i = 0; i < 4; i++) applyStimulus(2'b10, 1'b1, 1'b0, 8'h00, $sformatf("shl_%0d", i));
      observe(2'b00, "shl_final");

      applyStimulus(2'b11, 1'b0, 1'b0, 8'h5A, "load_5a");
      observe(2'b00, "oe_mode00");
      checkReleased(1'b0, 1'b1, 2'b00, "oe_g2_off");
      checkReleased(1'b1, 1'b0, 2'b00, "oe_g1_off");
      checkReleased(1'b0, 1'b0, 2'b11, "oe_load_mode");
      observe(2'b01, "oe_mode01");
      observe(2'b10, "oe_mode10");

      applyStimulus(2'b11, 1'b0, 1'b0, 8'h0F, "load_0f");
      for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b1, 1'b0, 8'h00, $sformatf("mid_shr_%0d", i));
      pulseClear("clr_mid_shift");
      applyStimulus(2'b00, 1'b1, 1'b1, 8'hFF, "hold_after_clr_0");
      applyStimulus(2'b00, 1'b1, 1'b1, 8'hFF, "hold_after_clr_1");
      observe(2'b00, "hold_after_clr_q");
      applyStimulus(2'b01, 1'b1, 1'b0, 8'h00, "resume_shr");
      observe(2'b00, "resume_shr_q");

`ifdef LS299_TIMING_EN
      applyStimulus(2'b11, 1'b0, 1'b0, 8'h00, "t_pre");
      @(negedge clk);
      {s1, s0} = 2'b11;
      tbDrive  = 1'b1;
      tbData   = 8'h0F;
      @(posedge clk);
      modelQ = 8'h0F;
      #20;
      checkOutput("t_clk_early", {7'b0, qaS}, 8'h00, 1'b1);
      #4;
      checkOutput("t_clk_late", {7'b0, qaS}, 8'h01, 1'b1);
      @(negedge clk);
      {s1, s0} = 2'b00;
      tbDrive  = 1'b0;
      clr      = 1'b1;
      #24;
      checkOutput("t_clr_early", {7'b0, qaS}, 8'h01, 1'b1);
      #4;
      checkOutput("t_clr_late", {6'b0, qhS, qaS}, 8'h00, 1'b1);
      clr    = 1'b0;
      modelQ = 8'h00;
`endif

      for (int n = 0; n < 200; n++) begin
         m = 2'($urandom_range(0, 3));
         applyStimulus(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                       $sformatf("rand_edge_%0d", n));
         if (n % 5 == 4) observe(2'($urandom_range(0, 2)), $sformatf("rand_q_%0d", n));
         if (n % 13 == 7 && modelQ != 8'h00) begin
            pick = $urandom_range(0, 2);
            case (pick)
               0:       checkReleased(1'b0, 1'b1, 2'b00, $sformatf("rand_off_%0d", n));
               1:       checkReleased(1'b1, 1'b1, 2'b01, $sformatf("rand_off_%0d", n));
               default: checkReleased(1'b0, 1'b0, 2'b11, $sformatf("rand_off_%0d", n));
            endcase
         end
         if (n % 37 == 20) pulseClear($sformatf("rand_clr_%0d", n));
      end

      @(negedge clk);
      ->obsEv;
      #(SETTLE + 2);
      if (sbQueue.size() != 0) begin
         checkCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sbQueue.size());
      end
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
